// File: rtl/uart_rx_axis_if.sv
// Byte stream leaving the UART receiver: data/valid from the receiver, ready from the consumer.
// valid stays high until a cycle with ready=1; data is held stable while valid is high.
interface uart_rx_axis_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver feeding a single-entry stream holding register, with framing-error
// and overrun pulses. rx is synchronised through two flops before any decision is made.
module uart_rx_axis #(
    parameter int CLOCKS_PER_PULSE = 8680,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    uart_rx_axis_if.master        m,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [2:0]            state_dbg
);
    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam int BW = $clog2(BITS_PER_WORD + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_WORD - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t                   state, state_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic [BW-1:0]            bit_idx, bit_n;
    logic [BITS_PER_WORD-1:0] shreg, shreg_n;
    logic                     word_rdy, word_rdy_n;
    logic                     frame_err_n;
    logic                     rx_meta, rx_s;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            word_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= shreg_n;
            word_rdy  <= word_rdy_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        bit_n       = bit_idx;
        shreg_n     = shreg;
        word_rdy_n  = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                // Re-check the line at mid start bit so short glitches are ignored.
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[BITS_PER_WORD-1:1]};
                    bit_n   = bit_idx + BW'(1);
                    if (bit_idx == BIT_LAST) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        word_rdy_n = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must return high before a new start is accepted.
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // shreg is untouched between the stop sample and this transfer, so it still holds the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            m.data  <= '0;
            m.valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_rdy) begin
                if (!m.valid || m.ready) begin
                    m.data  <= shreg;
                    m.valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m.valid && m.ready) begin
                m.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis at 16 clocks per bit: drives rx frames and compares
// received beats and flag pulses against hand-computed expectations.
module tb_uart_rx_axis;
    localparam int CPP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       frame_err;
    logic       overrun;
    logic [2:0] state_dbg;

    uart_rx_axis_if #(.W(8)) axis_if ();

    uart_rx_axis #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .m         (axis_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs change on negedge, so negedge+1 sees the values the next posedge acts on.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt = 0, ov_cnt = 0, dbl_cnt = 0, stab_cnt = 0;
    int         first_valid_cyc = -1;
    logic       fe_prev = 1'b0, ov_prev = 1'b0, v_prev = 1'b0, r_prev = 1'b0;
    logic [7:0] d_prev = '0;

    always begin
        @(negedge clk);
        #1;
        if (axis_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (axis_if.valid && axis_if.ready) got_q.push_back(axis_if.data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if ((frame_err && fe_prev) || (overrun && ov_prev)) dbl_cnt++;
        if (v_prev && !r_prev && (!axis_if.valid || axis_if.data != d_prev)) stab_cnt++;
        fe_prev = frame_err;
        ov_prev = overrun;
        v_prev  = axis_if.valid;
        r_prev  = axis_if.ready;
        d_prev  = axis_if.data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; leaves rx at the stop level so frames can follow back to back.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        rx = stop;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic check_beats(input string tag, input int base);
        check({tag, "_count"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check({tag, "_data"}, got_q[base + i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    int base, fe0, ov0, t0, lat;

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        axis_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", axis_if.valid, 0);
        check("rst_data", axis_if.data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        idle(5);

        // 1: single frame, latency from the falling start edge
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        first_valid_cyc = -1;
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        idle(20);
        exp_q.push_back(8'hA5);
        check_beats("t1", base);
        lat = first_valid_cyc - t0;
        check("t1_latency_window", (lat >= 150 && lat <= 160), 1);
        check("t1_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        // 2: short low glitch is rejected, following frame still received
        base = got_q.size(); fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check("t2_glitch_beats", got_q.size() - base, 0);
        check("t2_glitch_state", state_dbg, 0);
        send_byte(8'h3C, 1'b1);
        idle(20);
        exp_q.push_back(8'h3C);
        check_beats("t2", base);
        check("t2_frame_err", fe_cnt - fe0, 0);

        // 3: bad stop bit, then a held-low break
        base = got_q.size(); fe0 = fe_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        idle(40);
        check("t3_frame_err", fe_cnt - fe0, 1);
        check("t3_beats", got_q.size() - base, 0);
        check("t3_state", state_dbg, 0);

        // 4: overrun while the holding register is full
        axis_if.ready = 1'b0;
        base = got_q.size(); ov0 = ov_cnt;
        send_byte(8'h11, 1'b1);
        idle(2);
        send_byte(8'h22, 1'b1);
        idle(20);
        check("t4_overrun", ov_cnt - ov0, 1);
        check("t4_valid_held", axis_if.valid, 1);
        check("t4_data_held", axis_if.data, 8'h11);
        axis_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h11);
        check_beats("t4", base);
        check("t4_valid_drop", axis_if.valid, 0);

        // 5: reset in the middle of a frame
        base = got_q.size();
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        repeat (4 * CPP) @(negedge clk);
        rx = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_state", state_dbg, 0);
        rst = 1'b0;
        idle(20);
        check("t5_no_partial", got_q.size() - base, 0);
        send_byte(8'h5A, 1'b1);
        idle(20);
        exp_q.push_back(8'h5A);
        check_beats("t5", base);

        // 6: back-to-back frames with no idle gap
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h81, 1'b1);
        idle(20);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        check_beats("t6", base);
        check("t6_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        check("pulse_single_cycle", dbl_cnt, 0);
        check("data_stable_while_valid", stab_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
